// File: rtl/bus_mem_responder_if.sv
// bus_mem_responder_if: CPU byte bus, preload port and divided-clock handshake of the memory responder.
interface bus_mem_responder_if #(parameter int ADDR_W = 8);
    logic [7:0]        cpu_out_bus;
    logic              cpu_bus_pc;
    logic              cpu_bus_mar;
    logic              cpu_bus_mdr;
    logic              cpu_halt;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;
    logic              ard_clk;
    logic              ard_data_ready;
    logic              ard_receive_ready;
    logic [7:0]        in_bus;
    modport slave (
        input  cpu_out_bus, cpu_bus_pc, cpu_bus_mar, cpu_bus_mdr, cpu_halt, ld_en, ld_addr, ld_data,
        output ard_clk, ard_data_ready, ard_receive_ready, in_bus
    );
    modport master (
        output cpu_out_bus, cpu_bus_pc, cpu_bus_mar, cpu_bus_mdr, cpu_halt, ld_en, ld_addr, ld_data,
        input  ard_clk, ard_data_ready, ard_receive_ready, in_bus
    );
endinterface

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: byte-serial 16-bit memory responder clocked by a divided ard_clk.
// Define BUS_RESP_ERR_EN to add the sticky protocol-error output err.
module bus_mem_responder #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    bus_mem_responder_if.slave bus
`ifdef BUS_RESP_ERR_EN
    ,
    output logic err
`endif
);
    typedef enum logic [2:0] {IDLE, ADDR_HI, WD_LO, WD_HI, RD_LO, RD_HI, HALT} state_t;
    typedef enum logic [1:0] {T_NONE, T_FETCH, T_READ, T_WRITE} xfer_t;
    localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

    state_t            state_q;
    xfer_t             type_q, type_d;
    logic [7:0]        cnt_q, lo_q, hi_q, dlo_q, rdhi_q, inb_q;
    logic              ard_clk_q, dr_q, rr_q;
    logic              tick, bad_d, abort_d, halt_go, commit;
    logic [2:0]        flags;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [15:0]       rd_word;
    logic [15:0]       mem [2**ADDR_W];

    always_comb begin
        flags   = {bus.cpu_bus_pc, bus.cpu_bus_mar, bus.cpu_bus_mdr};
        tick    = cnt_q == CNT_MAX && !ard_clk_q && state_q != HALT;
        type_d  = flags == 3'b100 ? T_FETCH : flags == 3'b010 ? T_READ : flags == 3'b011 ? T_WRITE : T_NONE;
        bad_d   = flags != 3'b000 && type_d == T_NONE;
        abort_d = type_q == T_FETCH ? (bus.cpu_bus_mar | bus.cpu_bus_mdr) :
                  type_q == T_READ  ? (bus.cpu_bus_pc | bus.cpu_bus_mdr) : bus.cpu_bus_pc;
        halt_go = state_q == IDLE && bus.cpu_halt;
        commit  = state_q == WD_HI && tick && bus.cpu_bus_mdr;
        rd_addr = ADDR_W'({bus.cpu_out_bus, lo_q});
        wr_addr = ADDR_W'({hi_q, lo_q});
        rd_word = mem[rd_addr];
    end

    // Preload is written after the bus commit so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_addr] <= {bus.cpu_out_bus, dlo_q};
        if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            type_q    <= T_NONE;
            cnt_q     <= '0;
            ard_clk_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            dlo_q     <= '0;
            rdhi_q    <= '0;
            inb_q     <= '0;
            dr_q      <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            if (state_q == HALT || halt_go) begin
                cnt_q     <= '0;
                ard_clk_q <= 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q     <= '0;
                ard_clk_q <= ~ard_clk_q;
            end else cnt_q <= cnt_q + 8'd1;
            case (state_q)
                IDLE: begin
                    rr_q  <= !bus.cpu_halt;
                    dr_q  <= 1'b0;
                    inb_q <= '0;
                    if (bus.cpu_halt) state_q <= HALT;
                    else if (tick && type_d != T_NONE) begin
                        type_q  <= type_d;
                        lo_q    <= bus.cpu_out_bus;
                        state_q <= ADDR_HI;
                    end
                end
                ADDR_HI: if (tick) begin
                    if (abort_d) state_q <= IDLE;
                    else if (type_q == T_WRITE) begin
                        hi_q    <= bus.cpu_out_bus;
                        state_q <= WD_LO;
                    end else begin
                        hi_q    <= bus.cpu_out_bus;
                        inb_q   <= rd_word[7:0];
                        rdhi_q  <= rd_word[15:8];
                        dr_q    <= 1'b1;
                        rr_q    <= 1'b0;
                        state_q <= RD_LO;
                    end
                end
                WD_LO: if (tick && bus.cpu_bus_mdr) begin
                    dlo_q   <= bus.cpu_out_bus;
                    state_q <= WD_HI;
                end
                WD_HI: if (commit) state_q <= IDLE;
                RD_LO: if (tick) begin
                    inb_q   <= rdhi_q;
                    state_q <= RD_HI;
                end
                RD_HI: if (tick) begin
                    inb_q   <= '0;
                    dr_q    <= 1'b0;
                    rr_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    rr_q    <= 1'b0;
                    dr_q    <= 1'b0;
                    inb_q   <= '0;
                    state_q <= HALT;
                end
            endcase
        end
    end

`ifdef BUS_RESP_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (tick && ((state_q == IDLE && !bus.cpu_halt && bad_d) || (state_q == ADDR_HI && abort_d) ||
                 ((state_q == WD_LO || state_q == WD_HI) && (bus.cpu_bus_pc | bus.cpu_bus_mar)))) err <= 1'b1;
    end
`endif

    assign bus.ard_clk           = ard_clk_q;
    assign bus.ard_data_ready    = dr_q;
    assign bus.ard_receive_ready = rr_q;
    assign bus.in_bus            = inb_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed scoreboard bench for bus_mem_responder (CLK_DIV=4, ADDR_W=8).
module tb_bus_mem_responder;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_mem_responder_if #(.ADDR_W(8)) bus();
`ifdef BUS_RESP_ERR_EN
    logic err;
`endif
    bus_mem_responder #(.CLK_DIV(DIV), .ADDR_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef BUS_RESP_ERR_EN
        ,
        .err(err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model [256];
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        logic p;
        do begin
            p = bus.ard_clk;
            clk1();
            n++;
        end while (!(!p && bus.ard_clk) && n < 100);
        chk("tick_timeout", 16'(n < 100), 16'd1);
    endtask

    task automatic drive(input logic [7:0] b, input logic pc, input logic mar, input logic mdr);
        bus.cpu_out_bus = b;
        bus.cpu_bus_pc  = pc;
        bus.cpu_bus_mar = mar;
        bus.cpu_bus_mdr = mdr;
    endtask

    task automatic step(input logic [7:0] b, input logic pc, input logic mar, input logic mdr);
        drive(b, pc, mar, mdr);
        wait_tick();
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        clk1();
        bus.ld_en   = 1'b0;
        model[a]    = d;
    endtask

    task automatic read_start(input logic [15:0] a, input logic pc);
        logic [15:0] w;
        w = model[a[7:0]];
        sb.push_back(w[7:0]);
        sb.push_back(w[15:8]);
        step(a[7:0], pc, !pc, 1'b0);
        step(a[15:8], pc, !pc, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_byte(input string tag);
        logic [7:0] e;
        int hold = 0;
        e = sb.pop_front();
        chk(tag, 16'(bus.in_bus), 16'(e));
        chk({tag, "_rr"}, 16'(bus.ard_receive_ready), 16'd0);
        for (int i = 0; i < 2 * DIV; i++) begin
            if (bus.ard_data_ready === 1'b1 && bus.in_bus === e) hold++;
            clk1();
        end
        chk({tag, "_hold"}, 16'(hold), 16'(2 * DIV));
    endtask

    task automatic read_end(input string tag);
        chk({tag, "_dr"}, 16'(bus.ard_data_ready), 16'd0);
        chk({tag, "_in"}, 16'(bus.in_bus), 16'd0);
        chk({tag, "_rr"}, 16'(bus.ard_receive_ready), 16'd1);
    endtask

    task automatic read_all(input logic [15:0] a, input logic pc, input string tag);
        read_start(a, pc);
        read_byte({tag, "_lo"});
        read_byte({tag, "_hi"});
        read_end({tag, "_end"});
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_clk"}, 16'(bus.ard_clk), 16'd0);
        chk({tag, "_dr"}, 16'(bus.ard_data_ready), 16'd0);
        chk({tag, "_rr"}, 16'(bus.ard_receive_ready), 16'd0);
        chk({tag, "_in"}, 16'(bus.in_bus), 16'd0);
`ifdef BUS_RESP_ERR_EN
        chk({tag, "_err"}, 16'(err), 16'd0);
`endif
    endtask

    initial begin
        int n;
        int hi_cnt;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        bus.cpu_halt = 1'b0;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        for (int i = 0; i < 256; i++) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = 8'(i);
            bus.ld_data = 16'h0000;
            clk1();
        end
        bus.ld_en = 1'b0;
        repeat (2) clk1();
        reset_outputs("reset");

        rst_n = 1'b1;
        clk1();
        n = 1;
        chk("rr_after_reset", 16'(bus.ard_receive_ready), 16'd1);
        while (!bus.ard_clk && n < 50) begin
            clk1();
            n++;
        end
        chk("first_tick_latency", 16'(n), 16'(DIV));

        preload(8'h12, 16'hBEEF);
        read_all(16'h0012, 1'b1, "fetch");

        step(8'h34, 1'b0, 1'b1, 1'b1);
        step(8'h01, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'hCD, 1'b0, 1'b0, 1'b1);
        step(8'hAB, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        model[8'h34] = 16'hABCD;
        chk("write_done_rr", 16'(bus.ard_receive_ready), 16'd1);
        read_all(16'h0034, 1'b0, "read34");
        read_all(16'h0112, 1'b0, "wrap");

        step(8'h12, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        read_end("abort");
        wait_tick();
        read_end("abort_hold");
`ifdef BUS_RESP_ERR_EN
        chk("abort_err", 16'(err), 16'd1);
`endif

        preload(8'h56, 16'h5A5A);
        step(8'h56, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        step(8'h77, 1'b0, 1'b0, 1'b1);
        drive(8'h88, 1'b0, 1'b0, 1'b1);
        clk1();
        rst_n = 1'b0;
        clk1();
        reset_outputs("midwrite_reset");
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clk1();
        read_all(16'h0056, 1'b0, "midwrite_word");

        step(8'h12, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        read_end("invalid");
`ifdef BUS_RESP_ERR_EN
        chk("invalid_err", 16'(err), 16'd1);
`endif
        read_all(16'h0012, 1'b1, "after_invalid");

        step(8'h34, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        step(8'h22, 1'b0, 1'b0, 1'b1);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 8'h34;
        bus.ld_data = 16'h1111;
        step(8'h22, 1'b0, 1'b0, 1'b1);
        bus.ld_en = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        model[8'h34] = 16'h1111;
        read_all(16'h0034, 1'b0, "ld_wins");

        read_start(16'h0012, 1'b0);
        bus.cpu_halt = 1'b1;
        read_byte("halt_lo");
        read_byte("halt_hi");
        read_end("halt_end");
        clk1();
        hi_cnt = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (bus.ard_clk !== 1'b0) hi_cnt++;
            clk1();
        end
        chk("halt_clk_high_cycles", 16'(hi_cnt), 16'd0);
        chk("halt_rr", 16'(bus.ard_receive_ready), 16'd0);
        chk("halt_dr", 16'(bus.ard_data_ready), 16'd0);
        chk("halt_in", 16'(bus.in_bus), 16'd0);
        bus.cpu_halt = 1'b0;
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        clk1();
        chk("halt_reset_idle", 16'(bus.ard_receive_ready), 16'd1);
        read_all(16'h0034, 1'b0, "post_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
